// File: rtl/flat_buffer_reader.sv
// flat_buffer_reader: replays one flattened numChannels*depth block as depth numChannels-wide words
// Ports:
//   clk, rstb              clock, synchronous active-low reset
//   flat_in[k*nc+ch]       flattened block, slot k, channel ch
//   in_valid / in_ready    block handshake
//   out[ch]                current word (registered)
//   out_valid / out_ready  word handshake
//   out_first / out_last   frame markers, only when FLAT_BUFFER_READER_FRAME_EN is defined
// Words leave slot depth-1 first (oldest) down to slot 0.
// is_signed only changes how consumers read the samples; bit patterns pass through untouched.
module flat_buffer_reader #(
    parameter int numChannels = 16,
    parameter int bitwidth    = 8,
    parameter int depth       = 5,
    parameter int is_signed   = 0
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic [bitwidth-1:0] flat_in [numChannels*depth],
    input  logic                in_valid,
    output logic                in_ready,
    output logic [bitwidth-1:0] out [numChannels],
    output logic                out_valid,
    input  logic                out_ready
`ifdef FLAT_BUFFER_READER_FRAME_EN
    ,
    output logic                out_first,
    output logic                out_last
`endif
);
    localparam int CW = depth > 1 ? $clog2(depth) : 1;
    localparam logic [CW-1:0] LAST = CW'(depth - 1);
    if (depth < 1 || is_signed < 0 || is_signed > 1) begin : g_bad_param
        $error("flat_buffer_reader: depth must be >= 1 and is_signed 0 or 1");
    end
    typedef enum logic {IDLE, EMIT} state_t;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, sel;
    logic                out_valid_q, out_valid_d;
    logic [bitwidth-1:0] hold_q [numChannels*depth];
    logic [bitwidth-1:0] hold_d [numChannels*depth];
    logic [bitwidth-1:0] out_q [numChannels];
    logic [bitwidth-1:0] out_d [numChannels];
    logic                accept, consume, step;
    // A new block is only taken while idle or on the edge that consumes the last word.
    assign in_ready = rstb && (state_q == IDLE || (cnt_q == '0 && out_ready));
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;
    assign step     = consume && cnt_q != '0;
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        hold_d      = hold_q;
        out_d       = out_q;
        // sel is the slot shown next; the decrement is only used when cnt_q > 0.
        sel         = accept ? LAST : cnt_q - CW'(1);
        if (accept) begin
            state_d     = EMIT;
            cnt_d       = LAST;
            out_valid_d = 1'b1;
            hold_d      = flat_in;
        end else if (step) begin
            cnt_d = sel;
        end else if (consume) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end
        // On accept the first word comes straight from flat_in so it is valid next cycle.
        if (accept || step)
            for (int ch = 0; ch < numChannels; ch++)
                for (int k = 0; k < depth; k++)
                    if (sel == CW'(k))
                        out_d[ch] = accept ? flat_in[k*numChannels+ch] : hold_q[k*numChannels+ch];
    end
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q     <= IDLE;
            cnt_q       <= LAST;
            out_valid_q <= 1'b0;
            out_q       <= '{default: '0};
            hold_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            hold_q      <= hold_d;
        end
    end
    assign out       = out_q;
    assign out_valid = out_valid_q;
`ifdef FLAT_BUFFER_READER_FRAME_EN
    assign out_first = out_valid_q && cnt_q == LAST;
    assign out_last  = out_valid_q && cnt_q == '0;
`endif
endmodule

// File: tb/tb_flat_buffer_reader.sv
// tb_flat_buffer_reader: scoreboard bench for flat_buffer_reader at depth 5 and depth 1
module tb_flat_buffer_reader;
    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic [7:0] flat_a [80];
    logic       in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
    logic [7:0] out_a [16];
    logic [7:0] flat_b [16];
    logic       in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
    logic [7:0] out_b [16];
`ifdef FLAT_BUFFER_READER_FRAME_EN
    logic       first_a, last_a, first_b, last_b;
`endif
    int checks = 0, failures = 0;
    logic [127:0] qa[$], qb[$];
    int wa = 0, na = 0, vrun = 0, vmax = 0;
    always #5 clk = ~clk;
    flat_buffer_reader #(.numChannels(16), .bitwidth(8), .depth(5), .is_signed(0)) dut_a (
        .clk(clk), .rstb(rstb), .flat_in(flat_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out(out_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
`ifdef FLAT_BUFFER_READER_FRAME_EN
        , .out_first(first_a), .out_last(last_a)
`endif
    );
    flat_buffer_reader #(.numChannels(16), .bitwidth(8), .depth(1), .is_signed(1)) dut_b (
        .clk(clk), .rstb(rstb), .flat_in(flat_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out(out_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
`ifdef FLAT_BUFFER_READER_FRAME_EN
        , .out_first(first_b), .out_last(last_b)
`endif
    );
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [127:0] pack(input logic [7:0] w [16]);
        logic [127:0] r;
        for (int ch = 0; ch < 16; ch++) r[ch*8 +: 8] = w[ch];
        return r;
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic load_a(input logic [7:0] base);
        for (int i = 0; i < 80; i++) flat_a[i] = base + 8'(i);
    endtask
    // Monitors sample at negedge: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        logic [127:0] e;
        if (!rstb) begin
            qa.delete();
            wa = 0;
        end else begin
            vrun = out_valid_a ? vrun + 1 : 0;
            if (vrun > vmax) vmax = vrun;
`ifdef FLAT_BUFFER_READER_FRAME_EN
            check("a_first", 128'(first_a), 128'(out_valid_a && wa == 0));
            check("a_last", 128'(last_a), 128'(out_valid_a && wa == 4));
`endif
            if (out_valid_a && out_ready_a) begin
                if (qa.size() == 0) check("a_unexpected_word", 1, 0);
                else check("a_word", pack(out_a), qa.pop_front());
                wa = (wa == 4) ? 0 : wa + 1;
                na++;
            end
            if (in_valid_a && in_ready_a)
                for (int k = 4; k >= 0; k--) begin
                    for (int ch = 0; ch < 16; ch++) e[ch*8 +: 8] = flat_a[k*16+ch];
                    qa.push_back(e);
                end
        end
    end
    always @(negedge clk) begin
        if (!rstb) qb.delete();
        else begin
`ifdef FLAT_BUFFER_READER_FRAME_EN
            check("b_first", 128'(first_b), 128'(out_valid_b));
            check("b_last", 128'(last_b), 128'(out_valid_b));
`endif
            if (out_valid_b && out_ready_b) begin
                if (qb.size() == 0) check("b_unexpected_word", 1, 0);
                else check("b_word", pack(out_b), qb.pop_front());
            end
            if (in_valid_b && in_ready_b) qb.push_back(pack(flat_b));
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bit acc;
        load_a(8'h00);
        for (int ch = 0; ch < 16; ch++) flat_b[ch] = 8'(ch * 3);
        flat_b[0] = 8'hFD;
        step();
        step();
        check("rst_in_ready", 128'(in_ready_a), 0);
        check("rst_out_valid", 128'(out_valid_a), 0);
        check("rst_out", pack(out_a), 0);
        rstb = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 128'(in_ready_a), 1);
        // single block
        step();
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        @(negedge clk);
        check("blk_in_ready_low", 128'(in_ready_a), 0);
        check("blk_w0_ch0", 128'(out_a[0]), 64);
        repeat (4) step();
        @(negedge clk);
        check("blk_w4_ch15", 128'(out_a[15]), 15);
        check("blk_w4_in_ready", 128'(in_ready_a), 1);
        step();
        @(negedge clk);
        check("blk_done_valid", 128'(out_valid_a), 0);
        check("blk_done_ready", 128'(in_ready_a), 1);
        check("blk_count", 128'(na), 5);
        // backpressure at word 2
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        step();
        step();
        out_ready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_ch0", 128'(out_a[0]), 32);
            check("bp_hold_valid", 128'(out_valid_a), 1);
            step();
        end
        out_ready_a = 1'b1;
        repeat (4) step();
        check("bp_count", 128'(na), 10);
        check("bp_drained", 128'(qa.size()), 0);
        // back-to-back blocks
        vmax = 0;
        in_valid_a = 1'b1;
        step();
        load_a(8'h80);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (in_ready_a) acc = 1'b1;
            step();
        end
        in_valid_a = 1'b0;
        check("b2b_accepted", 128'(acc), 1);
        @(negedge clk);
        check("b2b_ch0", 128'(out_a[0]), 128'hC0);
        repeat (6) step();
        check("b2b_no_gap", 128'(vmax), 10);
        check("b2b_count", 128'(na), 20);
        // reset mid-block
        load_a(8'h00);
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        step();
        rstb = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 128'(in_ready_a), 0);
        step();
        rstb = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 128'(out_valid_a), 0);
        check("mid_rst_out", pack(out_a), 0);
        check("mid_rst_in_ready1", 128'(in_ready_a), 1);
        load_a(8'h40);
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        @(negedge clk);
        check("mid_restart_slot4", 128'(out_a[0]), 128'h80);
        repeat (5) step();
        check("mid_drained", 128'(qa.size()), 0);
        // depth=1 signed
        in_valid_b = 1'b1;
        step();
        @(negedge clk);
        check("d1_ch0", 128'(out_b[0]), 128'hFD);
        check("d1_valid", 128'(out_valid_b), 1);
        check("d1_ready_follows", 128'(in_ready_b), 1);
        step();
        out_ready_b = 1'b0;
        in_valid_b = 1'b0;
        @(negedge clk);
        check("d1_ready_bp", 128'(in_ready_b), 0);
        out_ready_b = 1'b1;
        step();
        step();
        @(negedge clk);
        check("d1_idle", 128'(out_valid_b), 0);
        check("d1_drained", 128'(qb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
